song_reader: RTL and testbench

//  Upstream sequencer for note_player: walks a song ROM, presents each note/duration

---
 rtl/song_reader.sv | 161 ++++++++++++++++
 tb/tb_song_reader.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/song_reader.sv
// song_reader: walks the internal song ROM one entry at a time.
// Each entry is presented to note_player with a one-cycle new_note pulse.
// The reader then waits for note_done before fetching the next entry.
// It pulses song_done at the end marker or after the last entry.
module song_reader #(
    parameter int NOTES_PER_SONG = 32,
    parameter int IDX_W          = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       play,
    input  logic [1:0] song,
    input  logic       note_done,
    output logic [5:0] note,
    output logic [5:0] duration,
    output logic       new_note,
    output logic       song_done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        WAIT_DONE,
        ADVANCE,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'(NOTES_PER_SONG - 1);

    state_t            state;
    state_t            next_state;
    logic [IDX_W-1:0]  index;
    logic [1:0]        song_q;
    logic              play_q;
    logic [11:0]       rom_data;
    logic              song_change;
    logic              play_rise;

    // Song table: {note[11:6], duration[5:0]}; a zero duration marks the end of a song.
    // Song 0 is a two-note song, song 1 fills every slot, song 2 has four notes,
    // song 3 has a single note.
    function automatic logic [11:0] rom_word(input logic [1:0] sel, input logic [IDX_W-1:0] idx);
        logic [11:0] word;
        word = 12'd0;
        case (sel)
            2'd0: begin
                if (int'(idx) == 0) word = {6'd12, 6'd5};
                else if (int'(idx) == 1) word = {6'd20, 6'd3};
            end
            2'd1: word = {6'd32 + 6'(idx), 6'(idx) + 6'd1};
            2'd2: begin
                if (int'(idx) < 4) word = {6'd40 + 6'(idx), 6'd7 + 6'(idx)};
            end
            default: begin
                if (int'(idx) == 0) word = {6'd63, 6'd1};
            end
        endcase
        return word;
    endfunction

    assign song_change = (song != song_q);
    assign play_rise   = play & ~play_q;

    // Synchronous ROM read: the address seen at this edge gives data in the next cycle.
    always_ff @(posedge clk) begin
        rom_data <= rom_word(song_q, index);
    end

    // Track the previous play level and the current song.
    // play_q updates every cycle, including while paused.
    always_ff @(posedge clk) begin
        if (reset) begin
            play_q <= 1'b0;
            song_q <= song;
        end else begin
            play_q <= play;
            song_q <= song;
        end
    end

    // Note index.
    // A song change restarts the song at entry 0, and DONE rewinds to entry 0.
    // While paused, ADVANCE holds the index.
    always_ff @(posedge clk) begin
        if (reset) begin
            index <= '0;
        end else if (song_change) begin
            index <= '0;
        end else if (state == ADVANCE && play) begin
            index <= index + 1'b1;
        end else if (state == DONE) begin
            index <= '0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    // A song change outside IDLE forces a fresh fetch ahead of everything else.
    // Pausing freezes the states that are busy running a song.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (play_rise) next_state = FETCH;
            end
            FETCH: begin
                if (song_change) next_state = FETCH;
                else if (play)   next_state = LOAD;
            end
            LOAD: begin
                if (song_change) next_state = FETCH;
                else if (play)   next_state = (rom_data[5:0] == 6'd0) ? DONE : WAIT_DONE;
            end
            WAIT_DONE: begin
                if (song_change)            next_state = FETCH;
                else if (play && note_done) next_state = (index == LAST_INDEX) ? DONE : ADVANCE;
            end
            ADVANCE: begin
                if (song_change) next_state = FETCH;
                else if (play)   next_state = FETCH;
            end
            DONE: begin
                next_state = song_change ? FETCH : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode.
    // The note pulse and its data appear only in a running LOAD with a real entry.
    // Reset and song-change cycles keep every output quiet.
    always_comb begin
        new_note  = 1'b0;
        note      = 6'd0;
        duration  = 6'd0;
        song_done = 1'b0;
        if (!reset && !song_change) begin
            case (state)
                LOAD: begin
                    if (play && rom_data[5:0] != 6'd0) begin
                        new_note = 1'b1;
                        note     = rom_data[11:6];
                        duration = rom_data[5:0];
                    end
                end
                DONE:    song_done = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_song_reader.sv
// tb_song_reader: directed cycle-by-cycle checks of song_reader.
// Each step drives the inputs for one cycle.
// Every output is compared against hand-computed values from the song table.
module tb_song_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       play;
    logic [1:0] song;
    logic       note_done;
    logic [5:0] note;
    logic [5:0] duration;
    logic       new_note;
    logic       song_done;

    int compared   = 0;
    int mismatched = 0;
    int pulses     = 0;

    song_reader #(.NOTES_PER_SONG(32), .IDX_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .song      (song),
        .note_done (note_done),
        .note      (note),
        .duration  (duration),
        .new_note  (new_note),
        .song_done (song_done)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Drive this cycle's inputs shortly after the rising edge, then let them settle.
    task automatic applyStimulus(input logic r, input logic p, input logic [1:0] s, input logic nd);
        reset     = r;
        play      = p;
        song      = s;
        note_done = nd;
        #3;
    endtask

    // Compare all four outputs against their expected values mid-cycle.
    task automatic checkOutput(input string tag, input logic exp_nn, input logic [5:0] exp_note,
                               input logic [5:0] exp_dur, input logic exp_sd);
        compared++;
        assert (new_note === exp_nn) else begin
            mismatched++;
            $error("[TB] FAIL %s new_note observed=%0b expected=%0b", tag, new_note, exp_nn);
        end
        compared++;
        assert (note === exp_note) else begin
            mismatched++;
            $error("[TB] FAIL %s note observed=%0d expected=%0d", tag, note, exp_note);
        end
        compared++;
        assert (duration === exp_dur) else begin
            mismatched++;
            $error("[TB] FAIL %s duration observed=%0d expected=%0d", tag, duration, exp_dur);
        end
        compared++;
        assert (song_done === exp_sd) else begin
            mismatched++;
            $error("[TB] FAIL %s song_done observed=%0b expected=%0b", tag, song_done, exp_sd);
        end
    endtask

    // Count any note pulse seen this cycle, then move to just after the next rising edge.
    task automatic endCycle();
        if (new_note === 1'b1) pulses++;
        @(posedge clk);
        #1;
    endtask

    // One full non-reset cycle: drive, check, advance.
    task automatic cyc(input logic p, input logic [1:0] s, input logic nd, input logic exp_nn,
                       input logic [5:0] exp_note, input logic [5:0] exp_dur, input logic exp_sd,
                       input string tag);
        applyStimulus(1'b0, p, s, nd);
        checkOutput(tag, exp_nn, exp_note, exp_dur, exp_sd);
        endCycle();
    endtask

    initial begin
        reset = 1'b1; play = 1'b0; song = 2'd0; note_done = 1'b0;
        @(posedge clk);
        #1;

        // Reset with play held high, then the first note of song 0 two cycles later.
        applyStimulus(1'b1, 1'b1, 2'd0, 1'b0);
        checkOutput("reset", 1'b0, 6'd0, 6'd0, 1'b0);
        endCycle();
        cyc(1, 0, 0, 0, 6'd0,  6'd0, 0, "idle_rise");
        cyc(1, 0, 0, 0, 6'd0,  6'd0, 0, "fetch0");
        cyc(1, 0, 0, 1, 6'd12, 6'd5, 0, "load0");
        cyc(1, 0, 0, 0, 6'd0,  6'd0, 0, "wait0");

        // note_done at k gives the next note at k+3.
        cyc(1, 0, 1, 0, 6'd0,  6'd0, 0, "nd_k");
        cyc(1, 0, 0, 0, 6'd0,  6'd0, 0, "adv_k1");
        cyc(1, 0, 0, 0, 6'd0,  6'd0, 0, "fetch_k2");
        cyc(1, 0, 0, 1, 6'd20, 6'd3, 0, "load1_k3");

        // Entry 2 of song 0 is the end marker: one song_done pulse, no note.
        cyc(1, 0, 0, 0, 6'd0, 6'd0, 0, "wait1");
        cyc(1, 0, 1, 0, 6'd0, 6'd0, 0, "nd1");
        cyc(1, 0, 0, 0, 6'd0, 6'd0, 0, "adv1");
        cyc(1, 0, 0, 0, 6'd0, 6'd0, 0, "fetch2");
        cyc(1, 0, 0, 0, 6'd0, 6'd0, 0, "load_end");
        cyc(1, 0, 0, 0, 6'd0, 6'd0, 1, "done0");
        cyc(1, 0, 0, 0, 6'd0, 6'd0, 0, "idle_held");
        cyc(0, 0, 0, 0, 6'd0, 6'd0, 0, "idle_low");

        // A new play edge restarts song 0 from entry 0.
        cyc(1, 0, 0, 0, 6'd0,  6'd0, 0, "restart_rise");
        cyc(1, 0, 0, 0, 6'd0,  6'd0, 0, "restart_fetch");
        cyc(1, 0, 0, 1, 6'd12, 6'd5, 0, "restart_load");

        // Pause in WAIT_DONE ignores note_done; the next real note_done still goes to entry 1.
        cyc(1, 0, 0, 0, 6'd0, 6'd0, 0, "wait_r");
        cyc(0, 0, 1, 0, 6'd0, 6'd0, 0, "pause_nd");
        cyc(0, 0, 0, 0, 6'd0, 6'd0, 0, "pause_hold");
        cyc(1, 0, 0, 0, 6'd0, 6'd0, 0, "resume_wait");
        cyc(1, 0, 1, 0, 6'd0, 6'd0, 0, "nd_r");
        cyc(1, 0, 0, 0, 6'd0, 6'd0, 0, "adv_r");
        cyc(1, 0, 0, 0, 6'd0, 6'd0, 0, "fetch_r");

        // Pause in LOAD holds the pulse back until play returns.
        cyc(0, 0, 0, 0, 6'd0,  6'd0, 0, "load_paused");
        cyc(0, 0, 0, 0, 6'd0,  6'd0, 0, "load_paused2");
        cyc(1, 0, 0, 1, 6'd20, 6'd3, 0, "load_resume");

        // Switch to song 1 from WAIT_DONE and play all 32 entries.
        cyc(1, 1, 0, 0, 6'd0, 6'd0, 0, "chg_to_s1");
        cyc(1, 1, 0, 0, 6'd0, 6'd0, 0, "s1_fetch0");
        pulses = 0;
        for (int i = 0; i < 32; i++) begin
            cyc(1, 1, 0, 1, 6'(32 + i), 6'(i + 1), 0, "s1_load");
            cyc(1, 1, 1, 0, 6'd0, 6'd0, 0, "s1_wait");
            if (i < 31) begin
                cyc(1, 1, 0, 0, 6'd0, 6'd0, 0, "s1_adv");
                cyc(1, 1, 0, 0, 6'd0, 6'd0, 0, "s1_fetch");
            end
        end
        cyc(1, 1, 0, 0, 6'd0, 6'd0, 1, "s1_done");
        compared++;
        assert (pulses == 32) else begin
            mismatched++;
            $error("[TB] FAIL s1_pulses observed=%0d expected=32", pulses);
        end
        cyc(1, 1, 0, 0, 6'd0, 6'd0, 0, "s1_idle");

        // Restart song 1 and walk it up to entry 7.
        cyc(0, 1, 0, 0, 6'd0, 6'd0, 0, "s1_play_low");
        cyc(1, 1, 0, 0, 6'd0, 6'd0, 0, "s1_rise");
        cyc(1, 1, 0, 0, 6'd0, 6'd0, 0, "s1_refetch");
        for (int i = 0; i < 7; i++) begin
            cyc(1, 1, 0, 1, 6'(32 + i), 6'(i + 1), 0, "s1b_load");
            cyc(1, 1, 1, 0, 6'd0, 6'd0, 0, "s1b_wait");
            cyc(1, 1, 0, 0, 6'd0, 6'd0, 0, "s1b_adv");
            cyc(1, 1, 0, 0, 6'd0, 6'd0, 0, "s1b_fetch");
        end
        cyc(1, 1, 0, 1, 6'd39, 6'd8, 0, "s1b_load7");

        // Switch to song 2 at entry 7: its first note arrives two cycles later.
        cyc(1, 2, 0, 0, 6'd0,  6'd0, 0, "chg_to_s2");
        cyc(1, 2, 0, 0, 6'd0,  6'd0, 0, "s2_fetch");
        cyc(1, 2, 0, 1, 6'd40, 6'd7, 0, "s2_load0");
        cyc(1, 2, 0, 0, 6'd0,  6'd0, 0, "s2_wait");

        // Reset in WAIT_DONE returns to IDLE with quiet outputs.
        // Held play then restarts song 2 at entry 0.
        applyStimulus(1'b1, 1'b1, 2'd2, 1'b0);
        checkOutput("mid_reset", 1'b0, 6'd0, 6'd0, 1'b0);
        endCycle();
        cyc(1, 2, 0, 0, 6'd0,  6'd0, 0, "post_reset");
        cyc(1, 2, 0, 0, 6'd0,  6'd0, 0, "pr_fetch");
        cyc(1, 2, 0, 1, 6'd40, 6'd7, 0, "pr_load0");
        cyc(1, 2, 1, 0, 6'd0,  6'd0, 0, "pr_wait");
        cyc(1, 2, 0, 0, 6'd0,  6'd0, 0, "pr_adv");
        cyc(1, 2, 0, 0, 6'd0,  6'd0, 0, "pr_fetch1");
        cyc(1, 2, 0, 1, 6'd41, 6'd8, 0, "pr_load1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
